// File: rtl/load_store_unit.sv
// Load/store unit with a byte-at-a-time block copy engine in front of a single-port data RAM.
// The RAM read path is combinational; all RAM writes commit on the rising edge of CLK.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | read latched address, capture read data
// STORE | write latched data to latched address
// CP_RD | read source byte into hold register
// CP_WR | write hold byte to destination, advance pointers
// RESP  | one-cycle completion pulse
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [ADDR_W-1:0] ReqDst,
    input  logic [7:0]        ReqLen,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespData,
    output logic              RespErr,
    output logic [ADDR_W-1:0] MemAddress,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, CP_RD, CP_WR, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src, dst;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] wdata, hold, resp_data;
    logic              err;

    always_ff @(posedge CLK) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ReqValid) begin
                    case (ReqOp)
                        2'b00:   state_nxt = LOAD;
                        2'b01:   state_nxt = STORE;
                        2'b10:   state_nxt = (ReqLen == 8'd0) ? RESP : CP_RD;
                        default: state_nxt = RESP;
                    endcase
                end
            end
            LOAD, STORE: state_nxt = RESP;
            CP_RD:       state_nxt = CP_WR;
            CP_WR:       state_nxt = (cnt == 8'd1) ? RESP : CP_RD;
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            src       <= '0;
            dst       <= '0;
            cnt       <= '0;
            wdata     <= '0;
            hold      <= '0;
            resp_data <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        src   <= ReqAddr;
                        dst   <= ReqDst;
                        cnt   <= ReqLen;
                        wdata <= ReqWData;
                        err   <= (ReqOp == 2'b11);
                    end
                end
                LOAD:  resp_data <= MemRData;
                STORE: resp_data <= wdata;
                CP_RD: hold      <= MemRData;
                CP_WR: begin
                    src       <= src + ADDR_W'(1);
                    dst       <= dst + ADDR_W'(1);
                    cnt       <= cnt - 8'd1;
                    resp_data <= hold;
                end
                default: ;
            endcase
        end
    end

    assign ReqReady   = (state == IDLE);
    assign Busy       = (state != IDLE);
    assign RespValid  = (state == RESP);
    assign RespErr    = (state == RESP) && err;
    assign RespData   = resp_data;
    assign MemAddress = (state == CP_WR) ? dst : src;
    assign MemWData   = (state == CP_WR) ? hold : wdata;
    // Reset gates the write strobe so an aborted copy cannot commit on the reset edge.
    assign MemWrite   = Reset_n && ((state == STORE) || (state == CP_WR));

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a behavioural data RAM and a response scoreboard.
// A hand-written sequence covers reset in the middle of a copy.
module tb_load_store_unit;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic       ReqValid;
    logic       ReqReady;
    logic [1:0] ReqOp;
    logic [7:0] ReqAddr, ReqDst, ReqLen, ReqWData;
    logic       RespValid;
    logic [7:0] RespData;
    logic       RespErr;
    logic [7:0] MemAddress;
    logic       MemWrite;
    logic [7:0] MemWData;
    logic [7:0] MemRData;
    logic       Busy;

    logic [7:0] mem [256] = '{default: 8'h00};
    int         wr_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign MemRData = mem[MemAddress];

    always @(posedge CLK) begin
        if (MemWrite) begin
            mem[MemAddress] <= MemWData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqAddr(ReqAddr), .ReqDst(ReqDst), .ReqLen(ReqLen), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr),
        .MemAddress(MemAddress), .MemWrite(MemWrite), .MemWData(MemWData),
        .MemRData(MemRData), .Busy(Busy)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_wr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk_st(input logic [7:0] a, input logic [7:0] d);
        mk_st = '{2'b01, a, 8'h00, 8'h00, d, d, 1'b0, 2, 1};
    endfunction

    function automatic vec_t mk_ld(input logic [7:0] a, input logic [7:0] e);
        mk_ld = '{2'b00, a, 8'h00, 8'h00, 8'h00, e, 1'b0, 2, 0};
    endfunction

    function automatic vec_t mk_cp(input logic [7:0] s, input logic [7:0] d,
                                   input logic [7:0] n, input logic [7:0] e);
        mk_cp = '{2'b10, s, d, n, 8'h00, e, 1'b0, 1 + 2 * int'(n), int'(n)};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   wr0;
        bit   done;
        wr0  = wr_cnt;
        done = 1'b0;
        @(negedge CLK);
        ReqValid = 1'b1;
        ReqOp    = v.op;
        ReqAddr  = v.addr;
        ReqDst   = v.dst;
        ReqLen   = v.len;
        ReqWData = v.wdata;
        check($sformatf("v%0d_ready", idx), ReqReady, 1);
        sb.push_back('{v.exp_data, v.exp_err, v.exp_lat});
        @(posedge CLK);
        #1;
        // Scramble request fields after accept; the unit must use its latched copy.
        ReqValid = 1'b0;
        ReqOp    = 2'($urandom);
        ReqAddr  = 8'($urandom);
        ReqDst   = 8'($urandom);
        ReqLen   = 8'($urandom);
        ReqWData = 8'($urandom);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge CLK);
            if (k == 1 && v.op == 2'b01) begin
                check($sformatf("v%0d_st_wr", idx), MemWrite, 1);
                check($sformatf("v%0d_st_addr", idx), MemAddress, v.addr);
                check($sformatf("v%0d_st_wdata", idx), MemWData, v.wdata);
            end
            if (RespValid) begin
                done = 1'b1;
                e = sb.pop_front();
                check($sformatf("v%0d_latency", idx), k, e.lat);
                check($sformatf("v%0d_data", idx), RespData, e.data);
                check($sformatf("v%0d_err", idx), RespErr, e.err);
            end
        end
        if (!done) begin
            check($sformatf("v%0d_resp_timeout", idx), 0, 1);
            e = sb.pop_front();
        end
        @(negedge CLK);
        check($sformatf("v%0d_resp_one_cycle", idx), RespValid, 0);
        check($sformatf("v%0d_ready_after", idx), ReqReady, 1);
        check($sformatf("v%0d_data_hold", idx), RespData, v.exp_data);
        check($sformatf("v%0d_writes", idx), wr_cnt - wr0, v.exp_wr);
    endtask

    initial begin
        int wr0;
        int resp_seen;
        ReqValid = 1'b0;
        ReqOp    = 2'b00;
        ReqAddr  = 8'h00;
        ReqDst   = 8'h00;
        ReqLen   = 8'h00;
        ReqWData = 8'h00;
        Reset_n  = 1'b0;

        vecs.push_back(mk_st(8'h10, 8'h5A));
        vecs.push_back(mk_ld(8'h10, 8'h5A));
        vecs.push_back(mk_st(8'h20, 8'h11));
        vecs.push_back(mk_st(8'h21, 8'h22));
        vecs.push_back(mk_st(8'h22, 8'h33));
        vecs.push_back(mk_st(8'h23, 8'h44));
        vecs.push_back(mk_cp(8'h20, 8'h40, 8'd4, 8'h44));
        vecs.push_back(mk_ld(8'h42, 8'h33));
        vecs.push_back(mk_st(8'hFE, 8'hAA));
        vecs.push_back(mk_st(8'hFF, 8'hBB));
        vecs.push_back(mk_st(8'h00, 8'hCC));
        vecs.push_back(mk_cp(8'hFE, 8'h01, 8'd3, 8'hCC));
        vecs.push_back(mk_ld(8'h01, 8'hAA));
        vecs.push_back(mk_ld(8'h03, 8'hCC));
        vecs.push_back(mk_st(8'h30, 8'h07));
        vecs.push_back(mk_cp(8'h30, 8'h31, 8'd3, 8'h07));
        vecs.push_back(mk_ld(8'h33, 8'h07));
        vecs.push_back('{2'b11, 8'h10, 8'h70, 8'd5, 8'hFF, 8'h07, 1'b1, 1, 0});
        vecs.push_back('{2'b10, 8'h10, 8'h70, 8'd0, 8'hFF, 8'h07, 1'b0, 1, 0});
        vecs.push_back(mk_ld(8'h70, 8'h00));
        vecs.push_back(mk_st(8'h50, 8'h01));
        vecs.push_back(mk_st(8'h51, 8'h02));
        vecs.push_back(mk_st(8'h52, 8'h03));
        vecs.push_back(mk_st(8'h53, 8'h04));

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", Busy, 0);
        check("rst_resp_valid", RespValid, 0);
        check("rst_resp_data", RespData, 0);
        check("rst_mem_write", MemWrite, 0);
        check("rst_mem_addr", MemAddress, 0);
        Reset_n = 1'b1;
        @(negedge CLK);
        check("rst_release_ready", ReqReady, 1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        check("mem_40", mem[8'h40], 8'h11);
        check("mem_41", mem[8'h41], 8'h22);
        check("mem_42", mem[8'h42], 8'h33);
        check("mem_43", mem[8'h43], 8'h44);
        check("mem_01", mem[8'h01], 8'hAA);
        check("mem_02", mem[8'h02], 8'hBB);
        check("mem_03", mem[8'h03], 8'hCC);
        check("mem_31", mem[8'h31], 8'h07);
        check("mem_32", mem[8'h32], 8'h07);
        check("mem_33", mem[8'h33], 8'h07);
        check("mem_34", mem[8'h34], 8'h00);
        check("mem_70", mem[8'h70], 8'h00);

        // Reset asserted during the second CP_WR of a four-byte copy.
        wr0 = wr_cnt;
        resp_seen = 0;
        @(negedge CLK);
        ReqValid = 1'b1;
        ReqOp    = 2'b10;
        ReqAddr  = 8'h50;
        ReqDst   = 8'h60;
        ReqLen   = 8'd4;
        @(posedge CLK);
        #1;
        ReqValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            if (RespValid) resp_seen++;
        end
        check("abort_in_cp_wr_addr", MemAddress, 8'h61);
        Reset_n = 1'b0;
        @(negedge CLK);
        check("abort_busy", Busy, 0);
        check("abort_resp_data", RespData, 0);
        check("abort_mem_addr", MemAddress, 0);
        if (RespValid) resp_seen++;
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (k == 0) check("abort_ready_after_release", ReqReady, 1);
            if (RespValid) resp_seen++;
        end
        check("abort_no_resp", resp_seen, 0);
        check("abort_writes", wr_cnt - wr0, 1);
        check("abort_mem_60", mem[8'h60], 8'h01);
        check("abort_mem_61", mem[8'h61], 8'h00);
        check("abort_scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have the parameter ADDR_W, default 8, meaning memory address width.
REQ-002 The module SHALL have the parameter DATA_W, default 8, meaning memory data width.
REQ-003 Port CLK SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port Reset_n SHALL be an input, 1 bit: reset, synchronous and active-low.
REQ-005 Port ReqValid SHALL be an input, 1 bit: the core presents a request.
REQ-006 Port ReqReady SHALL be an output, 1 bit: the unit accepts a request this cycle.
REQ-007 Port ReqOp SHALL be an input, 2 bits: 00 load, 01 store, 10 block copy, 11 reserved.
REQ-008 Port ReqAddr SHALL be an input, ADDR_W bits: load/store address, or copy source base.
REQ-009 Port ReqDst SHALL be an input, ADDR_W bits: copy destination base.
REQ-010 Port ReqLen SHALL be an input, 8 bits: copy byte count.
REQ-011 Port ReqWData SHALL be an input, DATA_W bits: store data.
REQ-012 Port RespValid SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-013 Port RespData SHALL be an output, DATA_W bits: load result, or last byte copied.
REQ-014 Port RespErr SHALL be an output, 1 bit: reserved opcode flag, qualified by RespValid.
REQ-015 Port MemAddress SHALL be an output, ADDR_W bits: data-RAM address.
REQ-016 Port MemWrite SHALL be an output, 1 bit: data-RAM write enable; the RAM writes on the rising edge.
REQ-017 Port MemWData SHALL be an output, DATA_W bits: data-RAM write data.
REQ-018 Port MemRData SHALL be an input, DATA_W bits: data-RAM read data, combinational from MemAddress in the same cycle.
REQ-019 Port Busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, STORE, CP_RD, CP_WR and RESP.
REQ-021 ReqReady SHALL equal 1 only in IDLE; a request is accepted on an edge where ReqValid=1 and ReqReady=1.
REQ-022 On accept, the unit SHALL latch ReqOp, ReqAddr, ReqDst, ReqLen and ReqWData; Req* changes after accept SHALL have no effect.
REQ-023 On accept, the next state SHALL be LOAD for 00, STORE for 01, CP_RD for 10 with ReqLen≠0, and RESP for 10 with ReqLen=0.
REQ-024 On accept of opcode 11, the next state SHALL be RESP with the error flag set.
REQ-025 Mem* outputs SHALL derive only from registered state, with no combinational path from Req* inputs.
REQ-026 In LOAD, MemAddress SHALL equal the latched address, MemWrite SHALL be 0, MemRData SHALL be captured into RespData, and the next state SHALL be RESP.
REQ-027 In STORE, MemAddress SHALL equal the latched address, MemWData SHALL equal the latched data, MemWrite SHALL be 1, RespData SHALL be set to the written data, and the next state SHALL be RESP.
REQ-028 In CP_RD, MemAddress SHALL equal src, MemWrite SHALL be 0, MemRData SHALL be captured into a hold register, and the next state SHALL be CP_WR.
REQ-029 In CP_WR, MemAddress SHALL equal dst, MemWData SHALL equal the hold register, and MemWrite SHALL be 1.
REQ-030 In CP_WR, src, dst and RespData SHALL update as src+1, dst+1 (modulo 2^ADDR_W) and RespData=hold, and the remaining count SHALL decrement.
REQ-031 CP_WR SHALL go to RESP when the remaining count reaches 0, else to CP_RD.
REQ-032 Copy SHALL proceed forward one byte at a time, so overlapping regions follow sequential semantics: dst=src+1 replicates M[src] over Len bytes.
REQ-033 Source and destination addresses SHALL wrap from 0xFF to 0x00 with no error.
REQ-034 In RESP, RespValid SHALL be 1 for exactly one cycle, RespErr SHALL equal the error flag, and the next state SHALL be IDLE.
REQ-035 RespValid SHALL have no backpressure; RespData SHALL hold its value until the next response.
REQ-036 For a zero-length copy or a reserved opcode, the unit SHALL perform no memory write and SHALL leave RespData unchanged.
REQ-037 Latency SHALL be: load/store RespValid 2 cycles after accept; copy 1+2·Len cycles after accept; Len=0 or opcode 11, 1 cycle after accept.
REQ-038 MemWrite SHALL be 0 in all states except STORE and CP_WR.

Reset
REQ-039 On an edge with Reset_n=0, state SHALL become IDLE and RespValid, RespErr, MemWrite, Busy, RespData, MemAddress, MemWData and all internal counters and registers SHALL become 0.
REQ-040 Reset during a copy SHALL abort it with no further writes, leaving already-written bytes intact, with no response issued.
REQ-041 The first cycle after reset release SHALL have ReqReady=1.

Verification
REQ-042 The bench SHALL cover: store 0x5A to 0x10 (accept at cycle N) -> MemWrite=1 at N+1 with address 0x10, RespValid at N+2; then load 0x10 -> RespData=0x5A at N+2.
REQ-043 The bench SHALL cover: copy src=0x20, dst=0x40, Len=4 of 11,22,33,44 -> M[0x40..0x43] = 11,22,33,44, RespValid at N+9, RespData=0x44.
REQ-044 The bench SHALL cover: copy src=0xFE, dst=0x01, Len=3 -> reads 0xFE,0xFF,0x00 and writes 0x01..0x03.
REQ-045 The bench SHALL cover: copy src=0x30, dst=0x31, Len=3 with M[0x30]=0x7 -> M[0x31..0x33]=0x7.
REQ-046 The bench SHALL cover: opcode 11, and Len=0 copy -> RespValid at N+1, RespErr=1 and 0 respectively, no MemWrite pulse.
REQ-047 The bench SHALL cover: Reset_n=0 on the second CP_WR of a Len=4 copy -> only the first byte is written, no RespValid, and ReqReady=1 after release.
